// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor reusing one full-adder cell over WIDTH cycles, LSB first.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0] count;
  logic carry, sum, carry_nxt, last, accept;
  assign sum       = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last      = count == CW'(WIDTH - 1);
  assign accept    = start && state != RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_comb
    state_nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // On the last RUN edge, carry still holds the carry into the MSB, so overflow is carry ^ carry_nxt.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B ^ {WIDTH{Sub}};
      carry <= Sub | Cin;
      count <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      res   <= {sum, res[WIDTH-1:1]};
      carry <= carry_nxt;
      count <= count + CW'(1);
      if (last) begin
        S    <= {sum, res[WIDTH-1:1]};
        Cout <= carry_nxt;
        Ovf  <= carry ^ carry_nxt;
      end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed checks of serial_add_sub at WIDTH=4 and WIDTH=8.
module tb_serial_add_sub;
  logic clk = 1'b0, rst = 1'b1;
  logic start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0, busy4, done4, cout4, ovf4;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0, busy8, done8, cout8, ovf8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  int n_asrt = 0, n_fail = 0, cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4), .Sub(sub4),
    .busy(busy4), .done(done4), .S(s4), .Cout(cout4), .Ovf(ovf4));

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8), .Sub(sub8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .Ovf(ovf8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one WIDTH=4 op; returns results, cycles until done and number of busy cycles seen.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub,
                     output logic [3:0] s, output logic co, output logic ov,
                     output int lat, output int nbusy);
    logic [3:0] prev;
    @(negedge clk);
    prev = s4;
    a4 = a; b4 = b; cin4 = cin; sub4 = sub; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = ~a; b4 = ~b; sub4 = ~sub;
    check("s_held_in_run", s4, prev);
    lat = 1; nbusy = 0;
    while (!done4 && lat < 20) begin
      nbusy += busy4 ? 1 : 0;
      @(negedge clk);
      lat++;
    end
    s = s4; co = cout4; ov = ovf4;
    check("busy_low_in_done", busy4, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done4, 1'b0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                     output logic [7:0] s, output logic co, output logic ov, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    s = s8; co = cout8; ov = ovf8;
  endtask

  initial begin
    logic [3:0] s;
    logic [7:0] s_w;
    logic co, ov;
    int lat, nbusy, t_prev;
    logic [3:0] ea [3], eb [3];
    logic ecin [3], esub [3];
    logic [4:0] eres [3];
    ea = '{4'd1, 4'd9, 4'd6}; eb = '{4'd2, 4'd4, 4'd7};
    ecin = '{1'b0, 1'b0, 1'b1}; esub = '{1'b0, 1'b1, 1'b0};
    eres = '{5'h03, 5'h15, 5'h0e};

    repeat (2) @(negedge clk);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_s", s4, 4'd0);
    check("rst_cout_ovf", {cout4, ovf4}, 2'b00);
    rst = 1'b0;

    op4(4'd7, 4'd8, 1'b1, 1'b0, s, co, ov, lat, nbusy);
    check("add_7_8_1_lat", lat, 5);
    check("add_7_8_1_busy", nbusy, 4);
    check("add_7_8_1", {co, ov, s}, {1'b1, 1'b0, 4'd0});

    op4(4'd5, 4'd3, 1'b0, 1'b1, s, co, ov, lat, nbusy);
    check("sub_5_3", {co, ov, s}, {1'b1, 1'b0, 4'd2});
    op4(4'd3, 4'd5, 1'b1, 1'b1, s, co, ov, lat, nbusy);
    check("sub_3_5", {co, ov, s}, {1'b0, 1'b0, 4'd14});
    op4(4'd7, 4'd15, 1'b0, 1'b1, s, co, ov, lat, nbusy);
    check("sub_7_m1", {co, ov, s}, {1'b0, 1'b1, 4'd8});
    op4(4'd7, 4'd1, 1'b0, 1'b0, s, co, ov, lat, nbusy);
    check("add_7_1_ovf", {co, ov, s}, {1'b0, 1'b1, 4'd8});

    for (int i = 0; i < 512; i++) begin
      op4(4'(i), 4'(i >> 4), i[8], 1'b0, s, co, ov, lat, nbusy);
      check($sformatf("sweep_%0d_%0d_%0d", i[3:0], i[7:4], i[8]),
            {co, s}, 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]));
    end

    // Start held high: each DONE cycle accepts the next op, operands garbled during RUN.
    @(negedge clk);
    a4 = ea[0]; b4 = eb[0]; cin4 = ecin[0]; sub4 = esub[0]; start4 = 1'b1;
    t_prev = cyc_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a4 = 4'hf; b4 = 4'hf; cin4 = 1'b1; sub4 = ~esub[k];
      lat = 0;
      while (!done4 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("b2b_period_%0d", k), cyc_cnt - t_prev, 5);
      check($sformatf("b2b_res_%0d", k), {cout4, s4}, eres[k]);
      t_prev = cyc_cnt;
      if (k < 2) begin
        a4 = ea[k+1]; b4 = eb[k+1]; cin4 = ecin[k+1]; sub4 = esub[k+1];
      end else start4 = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("s_held_idle", {cout4, s4}, 5'h0e);

    // Asynchronous reset in the middle of a run.
    a4 = 4'd7; b4 = 4'd8; cin4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy4, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy_done", {busy4, done4}, 2'b00);
    check("mid_rst_s", s4, 4'd0);
    check("mid_rst_cout_ovf", {cout4, ovf4}, 2'b00);
    rst = 1'b0;
    op4(4'd5, 4'd6, 1'b0, 1'b0, s, co, ov, lat, nbusy);
    check("post_rst_add", {co, ov, s}, {1'b0, 1'b1, 4'd11});

    op8(8'd255, 8'd1, 1'b0, 1'b0, s_w, co, ov, lat);
    check("w8_lat", lat, 9);
    check("w8_add_255_1", {co, ov, s_w}, {1'b1, 1'b0, 8'd0});
    op8(8'd128, 8'd1, 1'b0, 1'b1, s_w, co, ov, lat);
    check("w8_sub_128_1", {co, ov, s_w}, {1'b1, 1'b1, 8'd127});

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
